bcd_stopwatch_ctrl: RTL and testbench

Start/stop/clear controller and sequencer for a chain of cascaded decade (BCD 0–9) digit counters. It owns the run-state FSM and the tick prescaler, and generates the per-digit enable/carry ripple. It exposes the packed BCD count for display logic such as 7-segment scan. It sits between debounced pushbutton pulses and the display driver.

---
 rtl/bcd_stopwatch_ctrl.sv | 115 +++++++++++
 tb/tb_bcd_stopwatch_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch run-state FSM, tick prescaler and cascaded BCD digit counters.
// Optional lap capture registers are enabled by defining STOPWATCH_LAP_EN.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000,
  parameter int DIV_W    = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  running,
  output logic                  paused,
  output logic                  tick,
  output logic                  overflow
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   lap_bcd,
  output logic                  lap_valid
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

  state_t                state_reg, state_next;
  logic [DIV_W-1:0]      presc_reg, presc_next;
  logic [4*DIGITS-1:0]   bcd_reg;
  logic                  overflow_reg;
  logic [DIGITS:0]       carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
    end
  end

  // clear outranks stop, which outranks start
  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    if (clear) begin
      state_next = IDLE;
      presc_next = '0;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (stop)  state_next = PAUSE;
        PAUSE:   if (start && !stop) state_next = RUN;
        default: state_next = IDLE;
      endcase
      if (state_reg == RUN)
        presc_next = (presc_reg == PRESC_MAX) ? '0 : presc_reg + 1'b1;
    end
  end

  assign tick     = (state_reg == RUN) && (presc_reg == PRESC_MAX);
  assign running  = (state_reg == RUN);
  assign paused   = (state_reg == PAUSE);
  assign carry[0] = tick;

  // Digit gi advances when every lower digit is 9 on a tick edge
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit_cur;
      assign digit_cur    = bcd_reg[4*gi +: 4];
      assign carry[gi+1]  = carry[gi] && (digit_cur == 4'd9);

      always_ff @(posedge clk) begin
        if (rst || clear)
          bcd_reg[4*gi +: 4] <= 4'd0;
        else if (carry[gi])
          bcd_reg[4*gi +: 4] <= (digit_cur == 4'd9) ? 4'd0 : digit_cur + 4'd1;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear)
      overflow_reg <= 1'b0;
    else if (carry[DIGITS])
      overflow_reg <= 1'b1;
  end

  assign bcd_out  = bcd_reg;
  assign overflow = overflow_reg;

`ifdef STOPWATCH_LAP_EN
  logic [4*DIGITS-1:0] lap_bcd_reg;
  logic                lap_valid_reg;

  // Captures the pre-increment count when a tick lands on the same edge
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap_bcd_reg   <= '0;
      lap_valid_reg <= 1'b0;
    end else if (lap && (state_reg != IDLE)) begin
      lap_bcd_reg   <= bcd_reg;
      lap_valid_reg <= 1'b1;
    end
  end

  assign lap_bcd   = lap_bcd_reg;
  assign lap_valid = lap_valid_reg;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: directed scenarios plus random pulses, checked
// every cycle against an integer-count reference model.
module tb_bcd_stopwatch_ctrl;

  localparam int DIGITS = 2;
  localparam int TD     = 4;
  localparam int DW     = 3;
  localparam int MAXV   = 100;

  logic clk = 1'b0;
  logic rst, start, stop, clear, lap;
  logic [4*DIGITS-1:0] bcd_out;
  logic running, paused, tick, overflow;
`ifdef STOPWATCH_LAP_EN
  logic [4*DIGITS-1:0] lap_bcd;
  logic lap_valid;
`endif

  bcd_stopwatch_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TD), .DIV_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .bcd_out(bcd_out), .running(running), .paused(paused), .tick(tick),
    .overflow(overflow)
`ifdef STOPWATCH_LAP_EN
    , .lap(lap), .lap_bcd(lap_bcd), .lap_valid(lap_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model: 0=idle 1=run 2=pause; count kept as a plain integer
  int m_state, m_phase, m_count, m_lap;
  bit m_ov, m_lapv;

  function automatic logic [31:0] to_bcd(int n);
    logic [31:0] v;
    int x;
    v = '0;
    x = n;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return v;
  endfunction

  function automatic bit m_tick();
    return (m_state == 1) && (m_phase == TD - 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("bcd_out", 32'(bcd_out), to_bcd(m_count));
    check_eq("running", 32'(running), 32'(m_state == 1));
    check_eq("paused", 32'(paused), 32'(m_state == 2));
    check_eq("tick", 32'(tick), 32'(m_tick()));
    check_eq("overflow", 32'(overflow), 32'(m_ov));
`ifdef STOPWATCH_LAP_EN
    check_eq("lap_bcd", 32'(lap_bcd), to_bcd(m_lap));
    check_eq("lap_valid", 32'(lap_valid), 32'(m_lapv));
`endif
  endtask

  task automatic model_step(input bit s, input bit p, input bit c, input bit r, input bit l);
    bit tk;
    if (r || c) begin
      m_state = 0; m_phase = 0; m_count = 0; m_ov = 0; m_lap = 0; m_lapv = 0;
    end else begin
      tk = m_tick();
      if (l && m_state != 0) begin
        m_lap  = m_count;
        m_lapv = 1;
      end
      if (m_state == 1) m_phase = (m_phase + 1) % TD;
      if (tk) begin
        m_count = m_count + 1;
        if (m_count == MAXV) begin
          m_count = 0;
          m_ov = 1;
        end
      end
      if (m_state == 1 && p)            m_state = 2;
      else if (m_state == 0 && s)       m_state = 1;
      else if (m_state == 2 && s && !p) m_state = 1;
    end
  endtask

  // One clock: drive, compare pre-edge outputs, clock, advance model
  task automatic cycle(input bit s, input bit p, input bit c, input bit r, input bit l);
    start = s; stop = p; clear = c; rst = r; lap = l;
    check_outputs();
    @(posedge clk);
    #1;
    model_step(s, p, c, r, l);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic report(input string name);
    $display("txn %s: bcd=%h running=%0d paused=%0d overflow=%0d", name, bcd_out, running, paused, overflow);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; clear = 0; lap = 0;
    @(posedge clk);
    #1;
    model_step(0, 0, 0, 1, 0);
    check_eq("reset_bcd", 32'(bcd_out), 32'h0);
    check_eq("reset_running", 32'(running), 32'h0);
    check_eq("reset_paused", 32'(paused), 32'h0);
    check_eq("reset_tick", 32'(tick), 32'h0);
    check_eq("reset_overflow", 32'(overflow), 32'h0);
    report("reset");

    // 40 RUN cycles -> ten ticks
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    check_eq("t1_running", 32'(running), 32'h1);
    idle_cycles(40);
    check_eq("t1_bcd", 32'(bcd_out), 32'h10);
    check_eq("t1_overflow", 32'(overflow), 32'h0);
    report("run40");

    // 100 ticks wraps the two-digit count
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(400);
    check_eq("t2_bcd", 32'(bcd_out), 32'h00);
    check_eq("t2_overflow", 32'(overflow), 32'h1);
    cycle(0, 0, 1, 0, 0);
    check_eq("t2_clr_overflow", 32'(overflow), 32'h0);
    check_eq("t2_clr_running", 32'(running), 32'h0);
    report("wrap_clear");

    // pause mid-period then resume finishes the partial period
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(21);
    cycle(0, 1, 0, 0, 0);
    idle_cycles(20);
    check_eq("t3_paused", 32'(paused), 32'h1);
    check_eq("t3_bcd_held", 32'(bcd_out), 32'h05);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check_eq("t3_tick_2nd", 32'(tick), 32'h1);
    cycle(0, 0, 0, 0, 0);
    check_eq("t3_bcd_resume", 32'(bcd_out), 32'h06);
    report("pause_resume");

    // clear with tick, then stop with tick
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(3);
    check_eq("t4_tick_pre_clear", 32'(tick), 32'h1);
    cycle(0, 0, 1, 0, 0);
    check_eq("t4_clear_bcd", 32'(bcd_out), 32'h0);
    check_eq("t4_clear_idle", 32'(running | paused), 32'h0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(7);
    check_eq("t4_tick_pre_stop", 32'(tick), 32'h1);
    check_eq("t4_bcd_pre_stop", 32'(bcd_out), 32'h01);
    cycle(0, 1, 0, 0, 0);
    check_eq("t4_stop_bcd", 32'(bcd_out), 32'h02);
    check_eq("t4_stop_paused", 32'(paused), 32'h1);
    report("clear_stop_tick");

    // ignored pulses
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    check_eq("t5_stop_idle", 32'(running | paused), 32'h0);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(1, 0, 0, 0, 0);
    check_eq("t5_start_in_run", 32'(bcd_out), 32'h03);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check_eq("t5_start_stop_pause", 32'(paused), 32'h1);
    report("ignored_pulses");

    // randomized pulses
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0,
            $urandom_range(0, 7) == 0);
    report("random");

`ifdef STOPWATCH_LAP_EN
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    idle_cycles(148);
    cycle(0, 0, 0, 0, 1);
    check_eq("t6_lap37", 32'(lap_bcd), 32'h37);
    check_eq("t6_lap_valid", 32'(lap_valid), 32'h1);
    check_eq("t6_running", 32'(running), 32'h1);
    begin
      int budget;
      budget = 0;
      while (!(m_count == 39 && m_tick()) && budget < 60) begin
        cycle(0, 0, 0, 0, 0);
        budget++;
      end
      check_eq("t6_reach39_timeout", 32'(budget < 60), 32'h1);
    end
    cycle(0, 0, 0, 0, 1);
    check_eq("t6_lap39", 32'(lap_bcd), 32'h39);
    check_eq("t6_bcd40", 32'(bcd_out), 32'h40);
    cycle(0, 0, 1, 0, 0);
    check_eq("t6_clear_lap_valid", 32'(lap_valid), 32'h0);
    report("lap");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
